fifo_rr_arb: RTL and testbench

FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/arb_queue.sv | 74 +++++++
 rtl/fifo_rr_arb.sv | 168 ++++++++++++++++
 tb/tb_fifo_rr_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO arbiter.
//   - Default parameter constants for fifo_rr_arb and arb_queue.
//   - arb_state_e: burst FSM states, used only when ARB_BURST_EN is defined.
package fifo_arb_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefBurst = 4;

  typedef enum logic {
    ROTATE,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/arb_queue.sv
// Single-requester in-order queue with DEPTH entries.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (empties the queue)
//   push     write strobe; dropped when full unless a pop happens in the same cycle
//   pop      read strobe; ignored when empty
//   data_in  write data
//   full     DEPTH entries held (from registered state)
//   empty    no entries held (from registered state)
//   data_out head-of-queue entry
module arb_queue
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full     = (cnt_q == (AddrW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign data_out = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push to a full queue is still accepted.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pointers are log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AddrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AddrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/fifo_rr_arb.sv
// NREQ per-requester queues merged onto one registered output by round-robin arbitration.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   push       per-requester write strobe
//   data_in    requester i data at [i*WIDTH +: WIDTH]
//   full       per-queue full flag
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
//   data_out   granted beat data
//   out_src    index of the requester that supplied data_out
// Compile-time option: define ARB_BURST_EN to let a source keep the grant for up to
// BURST consecutive loads while its queue stays non-empty.
module fifo_rr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned BURST = DefBurst
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         push,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         full,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [$clog2(NREQ)-1:0] out_src
);

  localparam int unsigned IdxW = $clog2(NREQ);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (NREQ < 2 || NREQ > 16 || BURST < 1) begin : gen_bad_cfg
    $error("NREQ must be 2..16 and BURST >= 1");
  end

  logic [NREQ-1:0]  q_empty, q_full, q_pop;
  logic [WIDTH-1:0] q_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : gen_q
    arb_queue #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push    (push[i]),
      .pop     (q_pop[i]),
      .data_in (data_in[i*WIDTH +: WIDTH]),
      .full    (q_full[i]),
      .empty   (q_empty[i]),
      .data_out(q_data[i])
    );
  end

  assign full = q_full;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]  src_q, src_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [IdxW-1:0]  rr_sel, sel;
  logic             load, any_ne, do_load;

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign out_src   = src_q;

  assign load    = !out_valid_q || out_ready;
  assign any_ne  = ~&q_empty;
  assign do_load = load && any_ne;

  // First non-empty queue scanning last+1, last+2, ... modulo NREQ.
  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] idx_w;
    logic            found;
    rr_sel = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_q) + k) % NREQ;
      idx_w = IdxW'(idx);
      if (!found && !q_empty[idx_w]) begin
        rr_sel = idx_w;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_BURST_EN
  localparam int unsigned CntW = $clog2(BURST + 1);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            hold_ok;

  assign hold_ok = (state_q == HOLD) && !q_empty[last_q] && (cnt_q < CntW'(BURST));
  assign sel     = hold_ok ? last_q : rr_sel;
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (do_load) begin
      if (hold_ok) begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc < CntW'(BURST)) ? HOLD : ROTATE;
      end else begin
        cnt_d   = CntW'(1);
        state_d = (BURST > 1) ? HOLD : ROTATE;
      end
    end else if (load) begin
      // Load opportunity with nothing queued ends any burst in progress.
      cnt_d   = '0;
      state_d = ROTATE;
    end
  end
`else
  assign sel = rr_sel;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    src_d       = src_q;
    last_d      = last_q;
    q_pop       = '0;
    if (load) begin
      out_valid_d = any_ne;
      if (any_ne) begin
        data_d = q_data[sel];
        src_d  = sel;
        last_d = sel;
        q_pop  = NREQ'(1) << sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      src_q       <= '0;
      last_q      <= IdxW'(NREQ - 1);
`ifdef ARB_BURST_EN
      state_q     <= ROTATE;
      cnt_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      src_q       <= src_d;
      last_q      <= last_d;
`ifdef ARB_BURST_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Self-checking bench for fifo_rr_arb: directed scenarios plus randomized traffic, all
// compared every cycle against a queue-based reference model of the arbitration rules.
module tb_fifo_rr_arb;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         push;
  logic [NREQ*WIDTH-1:0]   data_in;
  logic [NREQ-1:0]         full;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        data_out;
  logic [$clog2(NREQ)-1:0] out_src;

  always #5 clk = ~clk;

  fifo_rr_arb #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NREQ (NREQ),
    .BURST(BURST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .data_in  (data_in),
    .full     (full),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .out_src  (out_src)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state.
  logic [WIDTH-1:0] mq [NREQ][$];
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_last;
  int               m_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies one clock edge worth of the arbitration rules to the model.
  task automatic model_step();
    int pick;
    bit held;
    bit load;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_last  = NREQ - 1;
      m_run   = 0;
      return;
    end
    load = !m_valid || out_ready;
    if (load) begin
      pick = -1;
      held = 1'b0;
`ifdef ARB_BURST_EN
      if (m_run > 0 && m_run < BURST && mq[m_last].size() > 0) begin
        pick = m_last;
        held = 1'b1;
      end
`endif
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (pick < 0 && mq[c].size() > 0) pick = c;
      end
      if (pick >= 0) begin
        m_data  = mq[pick].pop_front();
        m_src   = pick;
        m_last  = pick;
        m_valid = 1'b1;
        m_run   = held ? m_run + 1 : 1;
      end else begin
        m_valid = 1'b0;
        m_run   = 0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (push[i] && mq[i].size() < DEPTH) mq[i].push_back(data_in[i*WIDTH +: WIDTH]);
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] m_full;
    for (int i = 0; i < NREQ; i++) m_full[i] = (mq[i].size() == DEPTH);
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("out_src", 32'(out_src), 32'(m_src));
    check_eq("full", 32'(full), 32'(m_full));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    push = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int k;
  int exp_src [12];
  int ready_pct;

  initial begin
    rst       = 1'b1;
    push      = '0;
    data_in   = '0;
    out_ready = 1'b0;
    do_reset();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);

    // Single push to requester 2: visible one edge after the push edge.
    out_ready = 1'b1;
    push = 4'b0100;
    data_in[2*WIDTH +: WIDTH] = 8'hA5;
    tick();
    check_eq("lat_early_valid", 32'(out_valid), 32'd0);
    push = '0;
    tick();
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_data", 32'(data_out), 32'hA5);
    check_eq("lat_src", 32'(out_src), 32'd2);

    // All four queues loaded at once: grants in order 0,1,2,3.
    do_reset();
    out_ready = 1'b1;
    push = 4'b1111;
    for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = 8'(8'h10 * (i + 1));
    tick();
    push = '0;
    for (int i = 0; i < NREQ; i++) begin
      tick();
      check_eq("rr_src", 32'(out_src), 32'(i));
      check_eq("rr_data", 32'(data_out), 32'(8'h10 * (i + 1)));
    end

    // Fill queue 0 with the consumer stalled; the first beat sits in the output register.
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < DEPTH + 2; b++) begin
      push = 4'b0001;
      data_in[0 +: WIDTH] = 8'(8'h80 + b);
      tick();
      check_eq("fill_full0", 32'(full[0]), 32'(b >= DEPTH));
    end
    push = '0;
    // Stalled output holds steady.
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("stall_data", 32'(data_out), 32'h80);
      check_eq("stall_src", 32'(out_src), 32'd0);
      check_eq("stall_full0", 32'(full[0]), 32'd1);
    end
    k = 1;
    out_ready = 1'b1;
    repeat (DEPTH + 4) begin
      tick();
      if (out_valid) begin
        check_eq("drain_data", 32'(data_out), 32'(8'h80 + k));
        k++;
      end
    end
    check_eq("drain_count", 32'(k), 32'(DEPTH + 1));

`ifdef ARB_BURST_EN
    // Two queues of six beats each under burst mode.
    exp_src = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      push = 4'b0011;
      data_in[0 +: WIDTH]     = 8'(8'h00 + b);
      data_in[WIDTH +: WIDTH] = 8'(8'h40 + b);
      tick();
    end
    push = '0;
    check_eq("burst_src0", 32'(out_src), 32'(exp_src[0]));
    out_ready = 1'b1;
    for (int n = 1; n < 12; n++) begin
      tick();
      check_eq("burst_src", 32'(out_src), 32'(exp_src[n]));
    end
    tick();
    check_eq("burst_done", 32'(out_valid), 32'd0);
`endif

    // Reset in the middle of traffic discards everything.
    do_reset();
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      push = 4'b1111;
      data_in = $urandom;
      tick();
    end
    check_eq("mid_valid", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_full", 32'(full), 32'd0);
    rst  = 1'b0;
    push = 4'b1000;
    data_in[3*WIDTH +: WIDTH] = 8'h3C;
    tick();
    push = '0;
    tick();
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    check_eq("post_rst_src", 32'(out_src), 32'd3);
    check_eq("post_rst_data", 32'(data_out), 32'h3C);
    tick();
    check_eq("post_rst_empty", 32'(out_valid), 32'd0);

    // Randomized traffic with varying consumer throughput and occasional resets.
    ready_pct = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 64 == 0) ready_pct = $urandom_range(5, 100);
      rst       = ($urandom_range(0, 299) == 0);
      push      = NREQ'($urandom);
      data_in   = $urandom;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      tick();
    end
    rst       = 1'b0;
    push      = '0;
    out_ready = 1'b1;
    repeat (NREQ * DEPTH + 4) tick();
    check_eq("final_idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
